// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I decode stage.
//  - ALU control codes consumed by the execute-stage ALU
//  - RV32I major opcodes recognised by the decoder
//  - Immediate formats and operand-select encodings
//  - Helper for 12-bit sign extension
package alu_pkg;

  // ALU control codes. Bit 3 selects the alternate form (SUB, SRA).
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Immediate formats produced by the decoder
  typedef enum logic [1:0] {
    IMM_I     = 2'd0,
    IMM_S     = 2'd1,
    IMM_U     = 2'd2,
    IMM_SHAMT = 2'd3
  } imm_type_e;

  // Operand-select encodings
  localparam logic [1:0] A1_RS1  = 2'd0;
  localparam logic [1:0] A1_ZERO = 2'd1;
  localparam logic [1:0] A1_PC   = 2'd2;
  localparam logic       A2_RS2  = 1'b0;
  localparam logic       A2_IMM  = 1'b1;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_decoder.sv
// Combinational RV32I decoder: instruction word -> ALU control, immediate,
// operand selects, rd-write intent, store flag and illegal flag.
// Ports:
//  instr     in  32  instruction word
//  alu_cont  out 4   ALU control code (ADD when illegal)
//  imm       out 32  decoded immediate (I/S/U or zero-extended shamt)
//  a1_sel    out 2   operand 1 source (rs1 / zero / pc)
//  a2_sel    out 1   operand 2 source (rs2 / imm)
//  writes_rd out 1   instruction class writes rd (before the rd==0 check)
//  is_store  out 1   STORE instruction
//  illegal   out 1   instruction not decodable
module alu_ctrl_decoder
  import alu_pkg::*;
#(
  parameter int SUPPORT_SLT = 1
) (
  input  logic [31:0] instr,
  output logic [3:0]  alu_cont,
  output logic [31:0] imm,
  output logic [1:0]  a1_sel,
  output logic        a2_sel,
  output logic        writes_rd,
  output logic        is_store,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  imm_type_e  imm_type;
  logic       slt_off;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign slt_off = (SUPPORT_SLT == 0);

  always_comb begin
    alu_cont  = ALU_ADD;
    a1_sel    = A1_RS1;
    a2_sel    = A2_RS2;
    writes_rd = 1'b0;
    is_store  = 1'b0;
    illegal   = 1'b0;
    imm_type  = IMM_I;

    case (opcode)
      OPC_OP: begin
        writes_rd = 1'b1;
        alu_cont  = {funct7[5], funct3};
        // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
        if (!(funct7 == 7'b0000000 ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
          illegal = 1'b1;
        if (slt_off && funct3 == 3'b010)
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        writes_rd = 1'b1;
        a2_sel    = A2_IMM;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_type = IMM_SHAMT;
          alu_cont = {funct7[5], funct3};
          if (!(funct7 == 7'b0000000 || (funct3 == 3'b101 && funct7 == 7'b0100000)))
            illegal = 1'b1;
        end else begin
          // imm[10] is data here, so ADDI can never become SUB.
          alu_cont = {1'b0, funct3};
          if (slt_off && funct3 == 3'b010)
            illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        writes_rd = 1'b1;
        a1_sel    = A1_ZERO;
        a2_sel    = A2_IMM;
        imm_type  = IMM_U;
      end
      OPC_AUIPC: begin
        writes_rd = 1'b1;
        a1_sel    = A1_PC;
        a2_sel    = A2_IMM;
        imm_type  = IMM_U;
      end
      OPC_LOAD: begin
        writes_rd = 1'b1;
        a2_sel    = A2_IMM;
      end
      OPC_STORE: begin
        is_store = 1'b1;
        a2_sel   = A2_IMM;
        imm_type = IMM_S;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_cont = ALU_SUB;
          3'b100, 3'b101: begin
            alu_cont = ALU_SLT;
            if (slt_off) illegal = 1'b1;
          end
          3'b110, 3'b111: alu_cont = ALU_SLTU;
          default:        illegal  = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    // An illegal instruction is passed down as a harmless ADD with no side effects.
    if (illegal) begin
      alu_cont  = ALU_ADD;
      writes_rd = 1'b0;
      is_store  = 1'b0;
    end
  end

  always_comb begin
    case (imm_type)
      IMM_S:     imm = sext12({instr[31:25], instr[11:7]});
      IMM_U:     imm = {instr[31:12], 12'b0};
      IMM_SHAMT: imm = {27'b0, instr[24:20]};
      default:   imm = sext12(instr[31:20]);
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage for the RV32I integer ALU: decodes the fetched instruction,
// forms A1/A2/aluCont and registers them in a single valid/ready slot.
// Ports:
//  clk, rst              clock; asynchronous active-high reset
//  in_valid / in_ready   upstream handshake (in_ready = !out_valid || out_ready)
//  instr, pc             instruction word and its address
//  rs1_data, rs2_data    register-file read data
//  flush                 kills the held and the incoming instruction
//  out_valid / out_ready downstream handshake
//  A1, A2, aluCont       ALU operands and control code
//  rd, reg_write         destination register and write enable
//  store_data            rs2_data for stores, else 0
//  illegal               instruction not decodable
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SUPPORT_SLT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A1,
  output logic [XLEN-1:0] A2,
  output logic [3:0]      aluCont,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic [XLEN-1:0] store_data,
  output logic            illegal
);

  logic [3:0]      dec_alu_cont;
  logic [31:0]     dec_imm;
  logic [1:0]      dec_a1_sel;
  logic            dec_a2_sel;
  logic            dec_writes_rd;
  logic            dec_is_store;
  logic            dec_illegal;

  logic [XLEN-1:0] a1_d, a2_d, store_data_d;
  logic            reg_write_d;
  logic            accept;

  logic            out_valid_q;
  logic [XLEN-1:0] a1_q, a2_q, store_data_q;
  logic [3:0]      alu_cont_q;
  logic [4:0]      rd_q;
  logic            reg_write_q, illegal_q;

  alu_ctrl_decoder #(
    .SUPPORT_SLT(SUPPORT_SLT)
  ) u_dec (
    .instr    (instr),
    .alu_cont (dec_alu_cont),
    .imm      (dec_imm),
    .a1_sel   (dec_a1_sel),
    .a2_sel   (dec_a2_sel),
    .writes_rd(dec_writes_rd),
    .is_store (dec_is_store),
    .illegal  (dec_illegal)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    a1_d = rs1_data;
    if (dec_a1_sel == A1_ZERO)    a1_d = '0;
    else if (dec_a1_sel == A1_PC) a1_d = pc;
    a2_d = (dec_a2_sel == A2_IMM) ? dec_imm : rs2_data;
    if (dec_illegal) begin
      a1_d = '0;
      a2_d = '0;
    end
    store_data_d = dec_is_store ? rs2_data : '0;
    // Writes to x0 are suppressed here so execute never has to check rd.
    reg_write_d  = dec_writes_rd && (instr[11:7] != 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      a1_q         <= '0;
      a2_q         <= '0;
      alu_cont_q   <= ALU_ADD;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      store_data_q <= '0;
      illegal_q    <= 1'b0;
    end else begin
      if (flush)         out_valid_q <= 1'b0;
      else if (in_ready) out_valid_q <= in_valid;
      // Payload only moves on a real accept, so a held slot keeps its outputs.
      if (accept && !flush) begin
        a1_q         <= a1_d;
        a2_q         <= a2_d;
        alu_cont_q   <= dec_alu_cont;
        rd_q         <= instr[11:7];
        reg_write_q  <= reg_write_d;
        store_data_q <= store_data_d;
        illegal_q    <= dec_illegal;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign A1         = a1_q;
  assign A2         = a2_q;
  assign aluCont    = alu_cont_q;
  assign rd         = rd_q;
  assign reg_write  = reg_write_q;
  assign store_data = store_data_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage (SUPPORT_SLT=1 main instance,
// SUPPORT_SLT=0 side instance sharing the same stimulus).
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;

  logic        in_ready, out_valid, reg_write, illegal;
  logic [31:0] A1, A2, store_data;
  logic [3:0]  aluCont;
  logic [4:0]  rd;

  logic        n_in_ready, n_out_valid, n_reg_write, n_illegal;
  logic [31:0] n_A1, n_A2, n_store_data;
  logic [3:0]  n_aluCont;
  logic [4:0]  n_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(32), .SUPPORT_SLT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .A1(A1), .A2(A2), .aluCont(aluCont), .rd(rd), .reg_write(reg_write),
    .store_data(store_data), .illegal(illegal)
  );

  alu_decode_stage #(.XLEN(32), .SUPPORT_SLT(0)) dut_noslt (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready),
    .A1(n_A1), .A2(n_A2), .aluCont(n_aluCont), .rd(n_rd), .reg_write(n_reg_write),
    .store_data(n_store_data), .illegal(n_illegal)
  );

  typedef struct {
    string       name;
    logic [31:0] instr, pc, rs1, rs2;
    logic [31:0] a1, a2, sd;
    logic [3:0]  cont;
    logic        rw, ill, n_ill;
  } vec_t;

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || aluCont !== 4'b0000 || A1 !== 32'd0 || A2 !== 32'd0 ||
        rd !== 5'd0 || reg_write !== 1'b0 || store_data !== 32'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b aluCont=%b A1=%h A2=%h rd=%0d rw=%b sd=%h ill=%b required all zero",
               out_valid, aluCont, A1, A2, rd, reg_write, store_data, illegal);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_add();
    in_valid = 1'b1; out_ready = 1'b1;
    instr = 32'h002081B3; pc = 32'h0; rs1_data = 32'd5; rs2_data = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || A1 !== 32'd5 || A2 !== 32'd7 || aluCont !== 4'b0000 ||
        rd !== 5'd3 || reg_write !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL add_x3: ov=%b A1=%h A2=%h cont=%b rd=%0d rw=%b ill=%b required 1/5/7/0000/3/1/0",
               out_valid, A1, A2, aluCont, rd, reg_write, illegal);
    end
    $display("test_single_add: A1=%h A2=%h aluCont=%b rd=%0d", A1, A2, aluCont, rd);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_decode_vectors();
    vec_t v [14];
    v[0]  = '{"ADD",   32'h002081B3, 32'h0,   32'd5,        32'd7,     32'd5,        32'd7,        32'd0,     4'b0000, 1'b1, 1'b0, 1'b0};
    v[1]  = '{"SUB",   32'h40208233, 32'h0,   32'd9,        32'd4,     32'd9,        32'd4,        32'd0,     4'b1000, 1'b1, 1'b0, 1'b0};
    v[2]  = '{"SRAI",  32'h40435293, 32'h0,   32'h80000000, 32'd1,     32'h80000000, 32'd4,        32'd0,     4'b1101, 1'b1, 1'b0, 1'b0};
    v[3]  = '{"SLLIbad",32'h40431293,32'h0,   32'h11,       32'h22,    32'd0,        32'd0,        32'd0,     4'b0000, 1'b0, 1'b1, 1'b1};
    v[4]  = '{"ADDIm1",32'hFFF00093, 32'h0,   32'h10,       32'h3,     32'h10,       32'hFFFFFFFF, 32'd0,     4'b0000, 1'b1, 1'b0, 1'b0};
    v[5]  = '{"AUIPC", 32'h12345097, 32'h100, 32'h77,       32'h3,     32'h100,      32'h12345000, 32'd0,     4'b0000, 1'b1, 1'b0, 1'b0};
    v[6]  = '{"LUI",   32'hABCDE137, 32'h0,   32'h55,       32'h3,     32'd0,        32'hABCDE000, 32'd0,     4'b0000, 1'b1, 1'b0, 1'b0};
    v[7]  = '{"BLTU",  32'h0020E063, 32'h0,   32'd3,        32'd8,     32'd3,        32'd8,        32'd0,     4'b0011, 1'b0, 1'b0, 1'b0};
    v[8]  = '{"SW",    32'h0020A423, 32'h0,   32'h1000,     32'hDEAD,  32'h1000,     32'd8,        32'hDEAD,  4'b0000, 1'b0, 1'b0, 1'b0};
    v[9]  = '{"SLT",   32'h0020A1B3, 32'h0,   32'd1,        32'd2,     32'd1,        32'd2,        32'd0,     4'b0010, 1'b1, 1'b0, 1'b1};
    v[10] = '{"ADDx0", 32'h00208033, 32'h0,   32'd1,        32'd2,     32'd1,        32'd2,        32'd0,     4'b0000, 1'b0, 1'b0, 1'b0};
    v[11] = '{"BADOPC",32'hFFFFFFFF, 32'h0,   32'd1,        32'd2,     32'd0,        32'd0,        32'd0,     4'b0000, 1'b0, 1'b1, 1'b1};
    v[12] = '{"LW",    32'hFFC0A283, 32'h0,   32'h20,       32'd2,     32'h20,       32'hFFFFFFFC, 32'd0,     4'b0000, 1'b1, 1'b0, 1'b0};
    v[13] = '{"BGE",   32'h0020D063, 32'h0,   32'd4,        32'd6,     32'd4,        32'd6,        32'd0,     4'b0010, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      instr = v[i].instr; pc = v[i].pc; rs1_data = v[i].rs1; rs2_data = v[i].rs2;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || A1 !== v[i].a1 || A2 !== v[i].a2 || aluCont !== v[i].cont ||
          reg_write !== v[i].rw || illegal !== v[i].ill || store_data !== v[i].sd) begin
        errors++;
        $display("FAIL vec_%s: ov=%b A1=%h A2=%h cont=%b rw=%b ill=%b sd=%h required 1 %h %h %b %b %b %h",
                 v[i].name, out_valid, A1, A2, aluCont, reg_write, illegal, store_data,
                 v[i].a1, v[i].a2, v[i].cont, v[i].rw, v[i].ill, v[i].sd);
      end
      checks++;
      if (n_illegal !== v[i].n_ill) begin
        errors++;
        $display("FAIL noslt_%s: illegal=%b required %b", v[i].name, n_illegal, v[i].n_ill);
      end
      $display("vec %s: A1=%h A2=%h aluCont=%b rw=%b ill=%b noslt_ill=%b",
               v[i].name, A1, A2, aluCont, reg_write, illegal, n_illegal);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    logic holding = 1'b0;
    logic [31:0] h_a2 = '0;
    logic [4:0]  h_rd = '0;
    logic [11:0] imm;
    logic [4:0]  rdn;
    rs1_data = 32'd0; rs2_data = 32'd0; pc = 32'd0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      imm = 12'(16 + sent);
      rdn = 5'(sent + 1);
      in_valid  = (sent < 4);
      instr     = {imm, 5'd0, 3'b000, rdn, 7'b0010011};
      out_ready = !(cyc >= 2 && cyc <= 4);
      #3;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_hold_ready: cyc=%0d in_ready=%b required 0", cyc, in_ready);
        end
        if (holding) begin
          checks++;
          if (A2 !== h_a2 || rd !== h_rd) begin
            errors++;
            $display("FAIL b2b_hold_stable: cyc=%0d A2=%h rd=%0d required %h %0d", cyc, A2, rd, h_a2, h_rd);
          end
        end
        holding = 1'b1; h_a2 = A2; h_rd = rd;
      end else begin
        holding = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (A2 !== 32'(16 + got) || rd !== 5'(got + 1)) begin
          errors++;
          $display("FAIL b2b_order: item %0d A2=%h rd=%0d required %h %0d", got, A2, rd, 32'(16 + got), got + 1);
        end
        $display("b2b consume %0d: A2=%h rd=%0d", got, A2, rd);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: consumed %0d required 4 within cycle budget", got);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: out_valid=%b required 0 (no duplicate)", out_valid);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
    instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: out_valid=%b required 1", out_valid);
    end
    instr = 32'h40208233; flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill: out_valid=%b required 0", out_valid);
    end
    flush = 1'b0; out_ready = 1'b1; instr = 32'hABCDE137;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || A2 !== 32'hABCDE000 || A1 !== 32'd0 || rd !== 5'd2) begin
      errors++;
      $display("FAIL flush_next: ov=%b A1=%h A2=%h rd=%0d required 1 0 abcde000 2", out_valid, A1, A2, rd);
    end
    $display("test_flush: after-flush A2=%h", A2);
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    instr = 32'h40208233; rs1_data = 32'd9; rs2_data = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || aluCont !== 4'b1000) begin
      errors++;
      $display("FAIL areset_setup: ov=%b cont=%b required 1 1000", out_valid, aluCont);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || aluCont !== 4'b0000 || A1 !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_clear: ov=%b cont=%b A1=%h in_ready=%b required 0 0000 0 1",
               out_valid, aluCont, A1, in_ready);
    end
    $display("test_async_reset: out_valid=%b aluCont=%b", out_valid, aluCont);
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    test_reset();
    test_single_add();
    test_decode_vectors();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
